half_accum_feeder: RTL and testbench
====================================

// Module: half_accum_feeder
// PURPOSE
// - Initiator for the FP16 add-accumulator: buffers a vector of FP16 values, then drives
//   clear/in_valid/a/b pairs into the accumulator with hazard-safe spacing.
// - Captures the final accumulator output and presents the vector sum on a valid/ready result port.
// - Sits between a vector source (layer output stream) and the accumulator in the neural-network datapath.
// PARAMETERS
// - DEPTH      16  max vector length in FP16 elements (>=2)
// - ISSUE_GAP  6   idle cycles after each issued pair; must exceed accumulator in_valid->c update latency
// - CNT_W      $clog2(DEPTH+1) (localparam) element-count width
// PORTS
// - clk        in   1      clock, all logic on posedge
// - rstn       in   1      asynchronous active-low reset
// - load_valid in   1      source has an element
// - load_ready out  1      feeder accepts an element
// - load_data  in   16     FP16 element
// - load_last  in   1      element is last of the vector
// - acc_clear  out  1      to accumulator clear
// - acc_valid  out  1      to accumulator in_valid
// - acc_a      out  16     to accumulator a
// - acc_b      out  16     to accumulator b
// - acc_c      in   16     accumulator running sum c
// - res_valid  out  1      result available
// - res_ready  in   1      result consumer ready
// - res_data   out  16     FP16 vector sum
// - res_count  out  CNT_W  number of elements summed
// BEHAVIOUR
// - Reset (async, rstn=0): state LOAD; wr_cnt=rd_ptr=gap_cnt=0.
//   All outputs 0 except load_ready=1. Buffer contents are not cleared.
// - FSM states: LOAD -> CLEAR -> ISSUE <-> WAIT -> DONE -> LOAD.
// - LOAD:
//   - load_ready=1 while wr_cnt<DEPTH. A beat (load_valid & load_ready) writes buf[wr_cnt] and increments wr_cnt.
//   - Go to CLEAR on a beat with load_last=1, or on the beat that makes wr_cnt==DEPTH (load_last ignored then).
// - CLEAR: exactly one cycle, acc_clear=1, acc_valid=0; -> ISSUE.
// - ISSUE: exactly one cycle.
//   - acc_valid=1, acc_a=buf[rd_ptr], acc_b=(rd_ptr+1<wr_cnt) ? buf[rd_ptr+1] : 16'h0000.
//   - rd_ptr+=2; gap_cnt=ISSUE_GAP-1; -> WAIT.
// - WAIT: acc_valid=0; gap_cnt decrements. At gap_cnt==0: -> ISSUE if rd_ptr<wr_cnt, else -> DONE.
// - DONE:
//   - Entry registers res_data=acc_c and res_count=wr_cnt; res_valid=1.
//   - res_data and res_count are held stable while res_ready=0.
//   - On res_valid & res_ready: -> LOAD, wr_cnt=rd_ptr=0, res_valid=0 next cycle.
// - load_ready=0 in every state except LOAD; load_valid is ignored there.
// - Latency: with N elements and P=ceil(N/2), res_valid rises 2+P*(1+ISSUE_GAP) cycles after the
//   clock edge accepting the final beat.
// - No arithmetic in the feeder: FP16 padding is +0 (16'h0000); sums are formed only by the accumulator.
// - Odd N: final pair pads acc_b with +0. N=1 gives one issue.
// - Reset mid-operation: immediate return to LOAD. acc_valid/acc_clear drop asynchronously.
//   The accumulator is reset by its own rstn.
// - acc_* outputs are registered (driven from state/pointer flops); no combinational path load_*->acc_*.
// STRUCTURE
// - Shared package half_pkg:
//   - typedef logic [15:0] fp16_t
//   - FP16_ZERO=16'h0000, FP16_ONE=16'h3C00
//   - typedef enum feeder_state_t {LOAD,CLEAR,ISSUE,WAIT,DONE}
// - One sub-module: half_vec_buffer. DEPTH x 16 register file, 1 sync write port, 2 async read
//   ports (rd_ptr, rd_ptr+1).
// - Top-level half_accum_feeder holds the FSM, counters and result registers.
// TESTING (bench instantiates feeder + FP16 add-accumulator, default params)
// - Load 4 x 3C00 (last on 4th) -> two issues spaced 7 cycles; res_data=4400 (4.0), res_count=4.
// - Load 3C00,4000,4200 (1,2,3) -> second issue acc_a=4200, acc_b=0000; res_data=4600 (6.0), res_count=3.
// - Load single 4900 with last -> one issue (4900,0000); res_valid exactly 9 cycles after the beat; res_data=4900.
// - Load 16 x 3C00, load_last never set -> load_ready=0 after 16th beat; res_data=4C00 (16.0), res_count=16.
// - Hold res_ready=0 for 10 cycles in DONE -> res_valid=1 and res_data stable throughout, load_ready=0.
//   Then res_ready=1 -> next cycle load_ready=1.
// - Assert rstn=0 during WAIT of a 6-element vector -> acc_valid=0 and load_ready=1 immediately.
//   A following 2 x 4000 vector yields res_data=4400.

Source files
------------

// File: rtl/half_pkg.sv
// Shared FP16 types and the feeder state encoding.
package half_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        ISSUE,
        WAIT,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/half_vec_buffer.sv
// DEPTH x 16 register file: one synchronous write port, two asynchronous read ports.
// Out-of-range read addresses return +0 so a trailing odd element pads cleanly.
module half_vec_buffer
    import half_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [15:0]      wr_data,
    input  logic [PTR_W-1:0] rd_addr0,
    input  logic [PTR_W-1:0] rd_addr1,
    output logic [15:0]      rd_data0,
    output logic [15:0]      rd_data1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fp16_t mem [DEPTH];

    // Element capture; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < PTR_W'(DEPTH))) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Pair read at rd_ptr and rd_ptr+1.
    always_comb begin
        rd_data0 = FP16_ZERO;
        rd_data1 = FP16_ZERO;
        if (rd_addr0 < PTR_W'(DEPTH)) rd_data0 = mem[rd_addr0[AW-1:0]];
        if (rd_addr1 < PTR_W'(DEPTH)) rd_data1 = mem[rd_addr1[AW-1:0]];
    end

endmodule

// File: rtl/half_accum_feeder.sv
// Buffers an FP16 vector, feeds it pairwise into the FP16 add-accumulator with
// hazard-safe spacing, then presents the accumulated sum on a valid/ready port.
module half_accum_feeder
    import half_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int ISSUE_GAP = 6,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [15:0]      load_data,
    input  logic             load_last,
    output logic             acc_clear,
    output logic             acc_valid,
    output logic [15:0]      acc_a,
    output logic [15:0]      acc_b,
    input  logic [15:0]      acc_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [CNT_W-1:0] res_count
);

    // Read pointer is one bit wider than needed so rd_ptr+2 past the end cannot wrap.
    localparam int PTR_W = $clog2(DEPTH + 2);
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    feeder_state_t    state;
    logic [CNT_W-1:0] wr_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] wr_cnt_ext;
    logic [GAP_W-1:0] gap_cnt;
    logic             wr_en;
    fp16_t            rd_data0;
    fp16_t            rd_data1;
    fp16_t            pair_b;

    assign wr_en      = (state == LOAD) && load_valid && load_ready;
    assign wr_cnt_ext = PTR_W'(wr_cnt);
    assign rd_next    = rd_ptr + PTR_W'(1);
    assign pair_b     = (rd_next < wr_cnt_ext) ? rd_data1 : FP16_ZERO;

    half_vec_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_cnt_ext),
        .wr_data  (load_data),
        .rd_addr0 (rd_ptr),
        .rd_addr1 (rd_next),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    // Sequencer: load, clear, issue/wait pairs, then hold the result until taken.
    // acc_* are loaded on the edge entering ISSUE so they come straight from flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            rd_ptr     <= '0;
            gap_cnt    <= '0;
            load_ready <= 1'b1;
            acc_clear  <= 1'b0;
            acc_valid  <= 1'b0;
            acc_a      <= '0;
            acc_b      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_count  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        if (load_last || (wr_cnt == CNT_W'(DEPTH - 1))) begin
                            state      <= CLEAR;
                            load_ready <= 1'b0;
                            acc_clear  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    acc_clear <= 1'b0;
                    acc_valid <= 1'b1;
                    acc_a     <= rd_data0;
                    acc_b     <= pair_b;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    acc_valid <= 1'b0;
                    rd_ptr    <= rd_ptr + PTR_W'(2);
                    gap_cnt   <= GAP_W'(ISSUE_GAP - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (gap_cnt == '0) begin
                        if (rd_ptr < wr_cnt_ext) begin
                            acc_valid <= 1'b1;
                            acc_a     <= rd_data0;
                            acc_b     <= pair_b;
                            state     <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle samples the settled accumulator; afterwards hold.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_data  <= acc_c;
                        res_count <= wr_cnt;
                    end else if (res_ready) begin
                        res_valid  <= 1'b0;
                        wr_cnt     <= '0;
                        rd_ptr     <= '0;
                        load_ready <= 1'b1;
                        state      <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_half_accum_feeder.sv
// Bench for half_accum_feeder driving a behavioural FP16 add-accumulator.
module tb_half_accum_feeder;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_last = 1'b0;
    logic [15:0]      load_data = '0;
    logic             res_ready = 1'b0;
    logic             load_ready, acc_clear, acc_valid, res_valid;
    logic [15:0]      acc_a, acc_b, acc_c, res_data;
    logic [CNT_W-1:0] res_count;

    int checks = 0;
    int errors = 0;

    half_accum_feeder #(
        .DEPTH     (16),
        .ISSUE_GAP (6)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .acc_clear  (acc_clear),
        .acc_valid  (acc_valid),
        .acc_a      (acc_a),
        .acc_b      (acc_b),
        .acc_c      (acc_c),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count)
    );

    always #5 clk = ~clk;

    // FP16 <-> real helpers for the accumulator model (normal numbers and zero).
    function automatic real h2r(input logic [15:0] h);
        real m;
        real s;
        int  e;
        m = real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]);
        s = 1.0;
        if (e == 0) begin
            e = 1;
        end else begin
            m = m + 1.0;
        end
        for (int i = 0; i < 15 - e; i++) s = s / 2.0;
        for (int i = 0; i < e - 15; i++) s = s * 2.0;
        h2r = h[15] ? -(m * s) : (m * s);
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real        a;
        int         e;
        int         mant;
        logic       sgn;
        logic [4:0] ef;
        logic [9:0] mf;
        sgn = (r < 0.0);
        a   = sgn ? -r : r;
        if (a == 0.0) return 16'h0000;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        mant = $rtoi((a - 1.0) * 1024.0 + 0.5);
        ef = e[4:0];
        mf = mant[9:0];
        return {sgn, ef, mf};
    endfunction

    // Accumulator model: c updates two cycles after in_valid, clear zeroes it.
    logic        p_valid;
    logic [15:0] p_sum;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_c   <= '0;
            p_valid <= 1'b0;
            p_sum   <= '0;
        end else begin
            p_valid <= acc_valid;
            p_sum   <= r2h(h2r(acc_c) + h2r(acc_a) + h2r(acc_b));
            if (acc_clear) acc_c <= '0;
            else if (p_valid) acc_c <= p_sum;
        end
    end

    // Issue/clear monitor, sampled on the falling edge.
    int          cyc = 0;
    int          clr_n = 0;
    int          iss_cyc[$];
    logic [15:0] iss_a[$];
    logic [15:0] iss_b[$];
    always @(negedge clk) begin
        cyc++;
        if (acc_valid) begin
            iss_cyc.push_back(cyc);
            iss_a.push_back(acc_a);
            iss_b.push_back(acc_b);
        end
        if (acc_clear) clr_n++;
    end

    task automatic clear_mon();
        iss_cyc.delete();
        iss_a.delete();
        iss_b.delete();
        clr_n = 0;
    endtask

    task automatic load_vec(input logic [15:0] v [16], input int n, input bit with_last);
        clear_mon();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (load_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL load_ready_start got %b want 1", load_ready);
                end
            end
            load_valid = 1'b1;
            load_data  = v[i];
            load_last  = with_last && (i == n - 1);
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_res(output int cycles);
        cycles = 0;
        while (res_valid !== 1'b1 && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL res_valid_timeout got %b want 1 after %0d cycles", res_valid, cycles);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input int cnt, input int n_iss);
        checks++;
        if (res_data !== d) begin
            errors++;
            $display("FAIL %s_res_data got %h want %h", tag, res_data, d);
        end
        checks++;
        if (res_count !== CNT_W'(cnt)) begin
            errors++;
            $display("FAIL %s_res_count got %0d want %0d", tag, res_count, cnt);
        end
        checks++;
        if (iss_cyc.size() != n_iss) begin
            errors++;
            $display("FAIL %s_issue_count got %0d want %0d", tag, iss_cyc.size(), n_iss);
        end
        checks++;
        if (clr_n != 1) begin
            errors++;
            $display("FAIL %s_clear_count got %0d want 1", tag, clr_n);
        end
    endtask

    task automatic accept_res(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept got load_ready=%b res_valid=%b want 1 0", tag, load_ready, res_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (load_ready !== 1'b1 || acc_clear !== 1'b0 || acc_valid !== 1'b0 ||
            acc_a !== 16'h0 || acc_b !== 16'h0 || res_valid !== 1'b0 ||
            res_data !== 16'h0 || res_count !== '0) begin
            errors++;
            $display("FAIL reset_state got lr=%b clr=%b av=%b a=%h b=%h rv=%b rd=%h rc=%0d want 1 0 0 0000 0000 0 0000 0",
                     load_ready, acc_clear, acc_valid, acc_a, acc_b, res_valid, res_data, res_count);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_even();
        logic [15:0] v [16];
        int          c;
        foreach (v[i]) v[i] = 16'h3C00;
        load_vec(v, 4, 1'b1);
        wait_res(c);
        check_result("even", 16'h4400, 4, 2);
        if (iss_cyc.size() == 2) begin
            checks++;
            if (iss_cyc[1] - iss_cyc[0] != 7) begin
                errors++;
                $display("FAIL even_spacing got %0d want 7", iss_cyc[1] - iss_cyc[0]);
            end
            checks++;
            if (iss_a[0] !== 16'h3C00 || iss_b[0] !== 16'h3C00 || iss_a[1] !== 16'h3C00 || iss_b[1] !== 16'h3C00) begin
                errors++;
                $display("FAIL even_operands got %h %h %h %h want 3c00 x4", iss_a[0], iss_b[0], iss_a[1], iss_b[1]);
            end
        end
        accept_res("even");
    endtask

    task automatic test_odd();
        logic [15:0] v [16];
        int          c;
        foreach (v[i]) v[i] = 16'h0;
        v[0] = 16'h3C00; v[1] = 16'h4000; v[2] = 16'h4200;
        load_vec(v, 3, 1'b1);
        wait_res(c);
        check_result("odd", 16'h4600, 3, 2);
        if (iss_cyc.size() == 2) begin
            checks++;
            if (iss_a[0] !== 16'h3C00 || iss_b[0] !== 16'h4000 || iss_a[1] !== 16'h4200 || iss_b[1] !== 16'h0000) begin
                errors++;
                $display("FAIL odd_operands got %h %h %h %h want 3c00 4000 4200 0000", iss_a[0], iss_b[0], iss_a[1], iss_b[1]);
            end
        end
        accept_res("odd");
    endtask

    task automatic test_single();
        logic [15:0] v [16];
        int          c;
        foreach (v[i]) v[i] = 16'hFFFF;
        v[0] = 16'h4900;
        load_vec(v, 1, 1'b1);
        wait_res(c);
        checks++;
        if (c != 9) begin
            errors++;
            $display("FAIL single_latency got %0d want 9", c);
        end
        check_result("single", 16'h4900, 1, 1);
        if (iss_cyc.size() == 1) begin
            checks++;
            if (iss_a[0] !== 16'h4900 || iss_b[0] !== 16'h0000) begin
                errors++;
                $display("FAIL single_operands got %h %h want 4900 0000", iss_a[0], iss_b[0]);
            end
        end
        accept_res("single");
    endtask

    task automatic test_full_and_hold();
        logic [15:0] v [16];
        logic [15:0] held;
        int          c;
        foreach (v[i]) v[i] = 16'h3C00;
        load_vec(v, 16, 1'b0);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_load_ready got %b want 0", load_ready);
        end
        wait_res(c);
        check_result("full", 16'h4C00, 16, 8);
        held = res_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== held || res_count !== CNT_W'(16) || load_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got rv=%b rd=%h rc=%0d lr=%b want 1 %h 16 0",
                         i, res_valid, res_data, res_count, load_ready, held);
            end
        end
        load_valid = 1'b0;
        accept_res("full");
    endtask

    task automatic test_reset_mid();
        logic [15:0] v [16];
        int          c;
        int          n;
        foreach (v[i]) v[i] = 16'h3C00;
        load_vec(v, 6, 1'b1);
        n = 0;
        while (acc_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (acc_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue_timeout got %b want 1", acc_valid);
        end
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (acc_valid !== 1'b0 || load_ready !== 1'b1 || acc_clear !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got av=%b lr=%b clr=%b want 0 1 0", acc_valid, load_ready, acc_clear);
        end
        @(negedge clk);
        rstn = 1'b1;
        foreach (v[i]) v[i] = 16'h4000;
        load_vec(v, 2, 1'b1);
        wait_res(c);
        check_result("after_reset", 16'h4400, 2, 1);
        accept_res("after_reset");
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_single();
        test_full_and_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
